mc_main_fsm: RTL and testbench
==============================

Name: mc_main_fsm

Overview:
- Main sequencing controller for the multicycle RV32I core.
- Drives every datapath enable and mux select (PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA/B, ImmSrc, RegWrite, ALUControl) from the latched instruction fields and the ALU Zero flag.
- Adds a memory-ready handshake for the shared instruction/data memory, and a sticky illegal-instruction trap.
- Supports lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
- RESET_STATE, FETCH, state entered on reset (kept for bench override only).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- op  input  7  Instr[6:0]
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- Zero  input  1  ALU zero flag
- mem_ready  input  1  memory has completed the current access this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  0 = PC, 1 = Result
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction/OldPC register enable
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  output  2  00 RD2, 01 ImmExt, 10 constant 4
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  output  1  register file write enable
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction
- illegal_instr  output  1  high while in TRAP

Behaviour:
- State register is async-cleared to FETCH when reset = 0.
- While reset = 0, PCWrite, IRWrite, MemWrite, RegWrite and instr_done are forced to 0, and every other output is 0.
- Outputs are Moore (decoded from state) except:
  - PCWrite = PCUpdate | (Branch & Zero).
  - FETCH and memory states gate their enables with mem_ready.
- Unlisted outputs are 0 in every state. ImmSrc is decoded from op in all states: lw/I-type = 00, sw = 01, beq = 10, jal = 11, else 00.
- FETCH:
  - AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = add, ResultSrc = 10.
  - IRWrite = PCUpdate = mem_ready.
  - Next state: mem_ready ? DECODE : FETCH.
- DECODE:
  - ALUSrcA = 01, ALUSrcB = 01, ALUOp = add (precomputes branch target).
  - Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other -> TRAP.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = add. Next: lw -> MEMREAD, sw -> MEMWR.
- MEMREAD: AdrSrc = 1, ResultSrc = 00. Hold until mem_ready, then -> MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, instr_done = 1. Next -> FETCH.
- MEMWR:
  - AdrSrc = 1, ResultSrc = 00, MemWrite = 1, held high every cycle until and including the mem_ready cycle.
  - On the mem_ready cycle: instr_done = 1, next -> FETCH.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = funct. Next -> ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = funct. Next -> ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, instr_done = 1. Next -> FETCH.
- BEQ:
  - ALUSrcA = 10, ALUSrcB = 00, ALUOp = sub, ResultSrc = 00, Branch = 1.
  - PCWrite = Zero, instr_done = 1. Next -> FETCH.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = add, ResultSrc = 00, PCUpdate = 1. Next -> ALUWB (writes PC+4 to rd).
- TRAP: illegal_instr = 1, all write enables 0. Sticky until reset.
- ALU decode:
  - ALUOp add -> 000; ALUOp sub -> 001.
  - ALUOp funct, by funct3:
    - 000 -> 001 if (op[5] & funct7b5), else 000.
    - 010 -> 101.
    - 110 -> 011.
    - 111 -> 010.
    - any other -> 000.
- Latency with mem_ready held at 1: lw 5 cycles, sw 4, R/I 4, jal 4, beq 3. Each memory wait cycle adds exactly one cycle.
- Reset asserted mid-instruction: state goes to FETCH immediately and no further write enable is asserted.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
  - opcode constants and ALUOp/ALUControl/ImmSrc/mux-select localparams.
- One sub-module: alu_decoder (ALUOp, funct3, op5, funct7b5 -> ALUControl), purely combinational.

Test Plan:
1. lw (op = 0000011), mem_ready = 1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite = 1 and ResultSrc = 01 in cycle 5; instr_done in cycle 5 only.
2. sw (op = 0100011), mem_ready low 2 cycles in MEMWR -> MemWrite = 1 for 3 consecutive cycles with AdrSrc = 1; FETCH on the next cycle; total 6 cycles.
3. beq, Zero = 1 then Zero = 0 -> PCWrite = 1 in BEQ only when Zero = 1; ALUControl = 001; 3 cycles each.
4. R-type funct3 = 000 with funct7b5 = 1 -> ALUControl = 001 in EXECR. I-type funct3 = 000 with funct7b5 = 1 -> ALUControl = 000. funct3 = 010 -> 101.
5. op = 1111111 -> TRAP after DECODE; illegal_instr = 1 and all enables 0 for 20 cycles; reset exits to FETCH.
6. Reset pulsed low during MEMREAD with mem_ready = 1 -> RegWrite never asserts; state = FETCH; IRWrite = 0 while reset = 0.

Source files
------------

// File: rtl/mc_main_fsm_pkg.sv
// Shared control definitions for the multicycle RV32I sequencer: state set,
// opcodes, ALU operation classes and datapath mux encodings.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMREAD = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BEQ     = 4'd9,
        JAL     = 4'd10,
        TRAP    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_main_fsm_alu_decoder.sv
// Maps the sequencer's ALU operation class plus instruction fields onto the
// ALU control code. Purely combinational.
module alu_decoder
    import core_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type (op[5]=1) may select sub; addi ignores bit 30.
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Main sequencer for the multicycle RV32I core: drives datapath enables and
// mux selects, waits on the shared memory, and traps on unknown opcodes.
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC+4 when memory ready
// DECODE  | register read, precompute branch target OldPC+imm
// MEMADR  | effective address rs1+imm
// MEMREAD | load access, wait for memory
// MEMWB   | write loaded data to rd
// MEMWR   | store access, strobe held until memory ready
// EXECR   | R-type ALU operation
// EXECI   | I-type ALU operation
// ALUWB   | write ALUOut to rd
// BEQ     | compare, take branch on Zero
// JAL     | PC <= target, ALUResult = OldPC+4
// TRAP    | illegal instruction, sticky until reset
module mc_main_fsm
    import core_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal_instr
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_done;
    logic       w_illegal;
    logic       w_adr_src;
    logic [1:0] w_result_src;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu_control;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= RESET_STATE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_done       = 1'b0;
        w_illegal    = 1'b0;
        w_adr_src    = 1'b0;
        w_result_src = RES_ALUOUT;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_RD2;
        w_alu_op     = ALUOP_ADD;
        case (r_state)
            FETCH: begin
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_ir_write   = mem_ready;
                w_pc_update  = mem_ready;
                w_next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                w_src_a = SRCA_OLDPC;
                w_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_next_state = MEMADR;
                    OP_RTYPE:     w_next_state = EXECR;
                    OP_ITYPE:     w_next_state = EXECI;
                    OP_BEQ:       w_next_state = BEQ;
                    OP_JAL:       w_next_state = JAL;
                    default:      w_next_state = TRAP;
                endcase
            end
            MEMADR: begin
                w_src_a      = SRCA_RD1;
                w_src_b      = SRCB_IMM;
                w_next_state = (op == OP_SW) ? MEMWR : MEMREAD;
            end
            MEMREAD: begin
                w_adr_src = 1'b1;
                if (mem_ready) w_next_state = MEMWB;
            end
            MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_done       = 1'b1;
                w_next_state = FETCH;
            end
            MEMWR: begin
                // Strobe stays up through the ready cycle so the memory sees a stable request.
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_done       = 1'b1;
                    w_next_state = FETCH;
                end
            end
            EXECR: begin
                w_src_a      = SRCA_RD1;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = ALUWB;
            end
            EXECI: begin
                w_src_a      = SRCA_RD1;
                w_src_b      = SRCB_IMM;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = ALUWB;
            end
            ALUWB: begin
                w_reg_write  = 1'b1;
                w_done       = 1'b1;
                w_next_state = FETCH;
            end
            BEQ: begin
                w_src_a      = SRCA_RD1;
                w_alu_op     = ALUOP_SUB;
                w_branch     = 1'b1;
                w_done       = 1'b1;
                w_next_state = FETCH;
            end
            JAL: begin
                w_src_a      = SRCA_OLDPC;
                w_src_b      = SRCB_FOUR;
                w_pc_update  = 1'b1;
                w_next_state = ALUWB;
            end
            TRAP: begin
                w_illegal    = 1'b1;
                w_next_state = TRAP;
            end
            default: w_next_state = FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_op5         (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (w_alu_control)
    );

    // Outputs are gated by the reset pin itself so nothing strobes while it is low.
    assign PCWrite       = reset & (w_pc_update | (w_branch & Zero));
    assign AdrSrc        = reset & w_adr_src;
    assign MemWrite      = reset & w_mem_write;
    assign IRWrite       = reset & w_ir_write;
    assign RegWrite      = reset & w_reg_write;
    assign instr_done    = reset & w_done;
    assign illegal_instr = reset & w_illegal;
    assign ResultSrc     = reset ? w_result_src : 2'b00;
    assign ALUSrcA       = reset ? w_src_a : 2'b00;
    assign ALUSrcB       = reset ? w_src_b : 2'b00;
    assign ImmSrc        = reset ? imm_src_for(op) : 2'b00;
    assign ALUControl    = reset ? w_alu_control : 3'b000;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Randomized check of mc_main_fsm against a per-instruction cycle-sequence model.
module tb_mc_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    mc_main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .RegWrite(RegWrite), .instr_done(instr_done), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    wire [17:0] w_obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                         ImmSrc, ALUControl, RegWrite, instr_done, illegal_instr};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%05h expected=%05h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        mr;
        logic        zero;
        logic [17:0] exp;
        string       tag;
    } cyc_t;
    cyc_t q[$];

    function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] imm,
                                       input logic [2:0] alu, input logic rw, input logic dn,
                                       input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, dn, ill};
    endfunction

    function automatic logic [1:0] imm_exp(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] funct_exp(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o[5] && f7) ? 3'd1 : 3'd0;
            3'd2:    return 3'd5;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    task automatic push(input logic mr, input logic z, input logic [17:0] e, input string tag);
        cyc_t c;
        c.mr = mr; c.zero = z; c.exp = e; c.tag = tag;
        q.push_back(c);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Builds the expected cycle list for one instruction from the latency rules.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int wf, input int wm, input string nm);
        logic [1:0] im;
        im = imm_exp(o);
        op = o; funct3 = f3; funct7b5 = f7;
        for (int i = 0; i < wf; i++) push(1'b0, rb(), mk(0,0,0,0,2'd2,2'd0,2'd2,im,3'd0,0,0,0), {nm, "_fetchwait"});
        push(1'b1, rb(), mk(1,0,0,1,2'd2,2'd0,2'd2,im,3'd0,0,0,0), {nm, "_fetch"});
        push(rb(), rb(), mk(0,0,0,0,2'd0,2'd1,2'd1,im,3'd0,0,0,0), {nm, "_decode"});
        case (o)
            7'b0000011: begin
                push(rb(), rb(), mk(0,0,0,0,2'd0,2'd2,2'd1,im,3'd0,0,0,0), {nm, "_memadr"});
                for (int i = 0; i < wm; i++) push(1'b0, rb(), mk(0,1,0,0,2'd0,2'd0,2'd0,im,3'd0,0,0,0), {nm, "_rdwait"});
                push(1'b1, rb(), mk(0,1,0,0,2'd0,2'd0,2'd0,im,3'd0,0,0,0), {nm, "_memread"});
                push(rb(), rb(), mk(0,0,0,0,2'd1,2'd0,2'd0,im,3'd0,1,1,0), {nm, "_memwb"});
            end
            7'b0100011: begin
                push(rb(), rb(), mk(0,0,0,0,2'd0,2'd2,2'd1,im,3'd0,0,0,0), {nm, "_memadr"});
                for (int i = 0; i < wm; i++) push(1'b0, rb(), mk(0,1,1,0,2'd0,2'd0,2'd0,im,3'd0,0,0,0), {nm, "_wrwait"});
                push(1'b1, rb(), mk(0,1,1,0,2'd0,2'd0,2'd0,im,3'd0,0,1,0), {nm, "_memwr"});
            end
            7'b0110011, 7'b0010011: begin
                push(rb(), rb(), mk(0,0,0,0,2'd0,2'd2,o[5] ? 2'd0 : 2'd1,im,funct_exp(o,f3,f7),0,0,0), {nm, "_exec"});
                push(rb(), rb(), mk(0,0,0,0,2'd0,2'd0,2'd0,im,3'd0,1,1,0), {nm, "_aluwb"});
            end
            7'b1100011: push(rb(), z, mk(z,0,0,0,2'd0,2'd2,2'd0,im,3'd1,0,1,0), {nm, "_beq"});
            7'b1101111: begin
                push(rb(), rb(), mk(1,0,0,0,2'd0,2'd1,2'd2,im,3'd0,0,0,0), {nm, "_jal"});
                push(rb(), rb(), mk(0,0,0,0,2'd0,2'd0,2'd0,im,3'd0,1,1,0), {nm, "_aluwb"});
            end
            default: for (int i = 0; i < 20; i++) push(rb(), rb(), mk(0,0,0,0,2'd0,2'd0,2'd0,im,3'd0,0,0,1), {nm, "_trap"});
        endcase
    endtask

    task automatic play(input int n);
        int lim;
        lim = (n < q.size()) ? n : q.size();
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            mem_ready = q[i].mr;
            Zero      = q[i].zero;
            @(negedge clk);
            chk(q[i].tag, 32'(w_obs), 32'(q[i].exp));
        end
        q.delete();
    endtask

    // Called just after a negedge check; leaves the DUT in FETCH with mem_ready low.
    task automatic do_reset(input string tag);
        #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        Zero = 1'b1;
        #1 chk({tag, "_asserted"}, 32'(w_obs), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_held"}, 32'(w_obs), 32'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1 chk({tag, "_fetch"}, 32'(w_obs), 32'(mk(0,0,0,0,2'd2,2'd0,2'd2,imm_exp(op),3'd0,0,0,0)));
    endtask

    function automatic logic legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    initial begin
        logic [6:0] ops [6];
        logic [2:0] f3s [5];
        logic [6:0] o;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        f3s[0] = 3'd0; f3s[1] = 3'd2; f3s[2] = 3'd6; f3s[3] = 3'd7; f3s[4] = 3'd4;

        reset = 1'b0; op = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0;
        Zero = 1'b1; mem_ready = 1'b1;
        #12 chk("reset_outs", 32'(w_obs), 32'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        build(7'b0000011, 3'd2, 1'b0, 1'b0, 0, 0, "lw");     play(99);
        build(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 2, "sw");     play(99);
        build(7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0, "beq_t");  play(99);
        build(7'b1100011, 3'd0, 1'b0, 1'b0, 0, 0, "beq_nt"); play(99);
        build(7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0, "sub");    play(99);
        build(7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0, "addi");   play(99);
        build(7'b0110011, 3'd2, 1'b0, 1'b0, 0, 0, "slt");    play(99);
        build(7'b1101111, 3'd0, 1'b0, 1'b0, 1, 0, "jal");    play(99);

        build(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, "illegal"); play(99);
        do_reset("trap_rst");

        build(7'b0000011, 3'd0, 1'b0, 1'b0, 0, 0, "lw_cut"); play(3);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("lw_cut_memread", 32'(w_obs), 32'(mk(0,1,0,0,2'd0,2'd0,2'd0,2'd0,3'd0,0,0,0)));
        do_reset("mid_rst");

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) o = 7'($urandom);
            else o = ops[$urandom_range(0, 5)];
            build(o, ($urandom_range(0, 3) == 0) ? 3'($urandom) : f3s[$urandom_range(0, 4)],
                  rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rnd%0d", n));
            play(99);
            if (!legal(o)) do_reset($sformatf("rnd%0d_rst", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
